sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FifoDepth, default 16: number of entries; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter DataWidth, default 32: payload width in bits.
REQ-003 SHALL have parameter AlmostFullTh, default FifoDepth-2: almost_full threshold; range 1..FifoDepth.
REQ-004 SHALL have parameter AlmostEmptyTh, default 2: almost_empty threshold; range 0..FifoDepth-1.
REQ-005 SHALL have parameter OutReg, default 0: 0 = first-word-fall-through, 1 = registered read data.
REQ-006 SHALL have port clk, input, 1 bit: single clock; every flop uses the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-009 SHALL have ports wvalid (input, 1), wdata (input, DataWidth) and wready (output, 1): write handshake.
REQ-010 SHALL have ports rvalid (output, 1), rdata (output, DataWidth) and rready (input, 1): read handshake.
REQ-011 SHALL have port level, output, $clog2(FifoDepth+1) bits: current occupancy.
REQ-012 SHALL have ports almost_full and almost_empty, each output, 1 bit: threshold flags.

Function
REQ-013 SHALL accept a write on the cycle wvalid && wready, and a read on the cycle rvalid && rready.
REQ-014 SHALL return data in strict write order.
REQ-015 SHALL use write and read pointers in 0..FifoDepth-1 that wrap from FifoDepth-1 to 0, for any depth.
REQ-016 SHALL update level as: +1 on write only, -1 on read only, unchanged on simultaneous read+write or on neither.
REQ-017 SHALL drive wready = (level < FifoDepth) while not in reset and flush low; wready SHALL have no combinational path from rready.
REQ-018 SHALL reject a write attempted at level == FifoDepth even if a read happens in the same cycle; the sender must retry.
REQ-019 SHALL have no empty bypass: a write at level 0 SHALL NOT be readable in the same cycle.
REQ-020 SHALL, with OutReg=0, present an accepted write on rvalid/rdata one cycle after acceptance, with rdata read combinationally from storage.
REQ-021 SHALL, with OutReg=1, present an accepted write two cycles after acceptance through a one-entry output register.
REQ-022 SHALL, with OutReg=1, count the output-register entry in level, keeping total capacity at FifoDepth and refilling the output register on the cycle it is consumed.
REQ-023 SHALL hold rdata stable while rvalid && !rready.
REQ-024 SHALL drive almost_full = (level >= AlmostFullTh) and almost_empty = (level <= AlmostEmptyTh), both decoded from the level register.
REQ-025 SHALL give flush priority over all handshakes: while flush is high, wready = 0, rvalid = 0, and no write or read takes effect.
REQ-026 SHALL, on the cycle after flush is sampled high, have pointers = 0, level = 0, output register empty and almost_empty = 1.
REQ-027 SHALL leave rdata a don't-care whenever rvalid = 0.

Reset
REQ-028 SHALL, on reset assertion and without waiting for a clock edge, clear pointers, level and output-register valid, and drive rvalid = 0, wready = 0, level = 0, almost_full = 0, almost_empty = 1.
REQ-029 SHALL raise wready on the first rising clk edge after reset deassertion.
REQ-030 SHALL leave storage array contents unreset.
REQ-031 SHALL, on reset during active traffic, discard all entries; no partial handshake survives reset.

Structure
REQ-032 SHALL take the level-width helper (clog2 of depth+1) and the default depth/width constants from the shared commons package fifo_pkg.
REQ-033 SHALL implement the OutReg=1 stage as sub-module fifo_out_stage (one-entry valid/ready register), instantiated by generate only when OutReg=1.
REQ-034 SHALL reject illegal parameter combinations with an elaboration-time assertion.

Verification (FifoDepth=5, DataWidth=8, AlmostFullTh=3, AlmostEmptyTh=1, OutReg=0 unless noted)
REQ-035 SHALL cover fill: write 0x01..0x06 back-to-back, rready=0 -> almost_full rises when level reaches 3, wready falls after the 5th accept, 0x06 is not accepted, and level = 5.
REQ-036 SHALL cover wrap: fill 5, read 3, write 0xA0..0xA2, drain -> read order 0x04, 0x05, 0xA0, 0xA1, 0xA2, confirming the pointer wraps 4 -> 0.
REQ-037 SHALL cover simultaneous read+write: at level 2, wvalid = rready = 1 for 10 cycles -> level stays 2 and data order is preserved; then at level 5 with rready = 1 -> no write is accepted that cycle.
REQ-038 SHALL cover flush: at level 4 with wvalid = 1, pulse flush for one cycle -> next cycle level = 0, rvalid = 0, the flushed-cycle write is lost, and a subsequent write 0x55 is read back as 0x55.
REQ-039 SHALL cover reset: assert reset asynchronously mid-cycle at level 3 -> rvalid, wready and level go to 0 before the next edge; wready = 1 one edge after release.
REQ-040 SHALL cover OutReg=1: write 0x11 at cycle 0 -> rvalid at cycle 2; back-to-back reads of 5 entries sustain one read per cycle, and level reaches 5 with one entry held in the output register.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO default sizes and the occupancy-width helper
package fifo_pkg;
  localparam int DefDepth = 16;
  localparam int DefWidth = 32;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_out_stage.sv
// fifo_out_stage: one-entry valid/ready output register that refills on the cycle it drains
module fifo_out_stage #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data,
  input  logic                 out_ready
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) out_valid <= 1'b0;
    else out_valid <= flush ? 1'b0 : in_valid || (out_valid && !out_ready);
  always_ff @(posedge clk)
    if (in_valid && in_ready) out_data <= in_data;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, any depth, occupancy flags, optional registered read data
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FifoDepth     = DefDepth,
  parameter int DataWidth     = DefWidth,
  parameter int AlmostFullTh  = FifoDepth - 2,
  parameter int AlmostEmptyTh = 2,
  parameter bit OutReg        = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           wvalid,
  input  logic [DataWidth-1:0]           wdata,
  output logic                           wready,
  output logic                           rvalid,
  output logic [DataWidth-1:0]           rdata,
  input  logic                           rready,
  output logic [lvl_w(FifoDepth)-1:0]    level,
  output logic                           almost_full,
  output logic                           almost_empty
);
  localparam int LW = lvl_w(FifoDepth);
  localparam int PW = $clog2(FifoDepth);
  if (FifoDepth < 2 || DataWidth < 1 || AlmostFullTh < 1 || AlmostFullTh > FifoDepth ||
      AlmostEmptyTh < 0 || AlmostEmptyTh > FifoDepth - 1) begin : g_bad_params
    $error("sync_fifo: illegal parameter combination");
  end
  logic [DataWidth-1:0] mem [FifoDepth];
  logic [DataWidth-1:0] core_data;
  logic [PW-1:0] wptr, rptr;
  logic live, wr, rd, pop, core_valid, out_v;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FifoDepth - 1) ? '0 : p + 1'b1;
  endfunction
  // live holds wready low until the first edge after reset release
  assign wready       = live && !flush && level < LW'(FifoDepth);
  assign wr           = wvalid && wready;
  assign rd           = rvalid && rready;
  assign core_data    = mem[rptr];
  assign core_valid   = !flush && level > LW'(out_v);
  assign almost_full  = level >= LW'(AlmostFullTh);
  assign almost_empty = level <= LW'(AlmostEmptyTh);
  if (OutReg) begin : g_out
    logic in_ready;
    fifo_out_stage #(.DataWidth(DataWidth)) u_out (
      .clk, .reset, .flush,
      .in_valid(core_valid), .in_data(core_data), .in_ready,
      .out_valid(out_v), .out_data(rdata), .out_ready(rready)
    );
    assign rvalid = out_v && !flush;
    assign pop    = core_valid && in_ready;
  end else begin : g_fwft
    assign out_v  = 1'b0;
    assign rvalid = core_valid;
    assign rdata  = core_data;
    assign pop    = rd;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      live  <= 1'b0;
      level <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      live  <= 1'b1;
      level <= flush ? '0 : level + LW'(wr) - LW'(rd);
      wptr  <= flush ? '0 : wr ? nxt(wptr) : wptr;
      rptr  <= flush ? '0 : pop ? nxt(rptr) : rptr;
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives a first-word-fall-through and a registered-output FIFO with shared stimulus
module tb_sync_fifo;
  typedef struct { logic [7:0] d; int acc; } ent_t;
  logic clk = 0, reset = 1, flush = 0, wvalid = 0, rready = 0;
  logic [7:0] wdata = 0;
  logic wready0, rvalid0, af0, ae0, wready1, rvalid1, af1, ae1;
  logic [7:0] rdata0, rdata1;
  logic [2:0] level0, level1;
  ent_t q0[$], q1[$];
  bit live;
  int cyc = 0, passed = 0, total = 0;
  logic o_wr[2], o_rv[2], o_af[2], o_ae[2], e_wr[2], e_rv[2], e_af[2], e_ae[2];
  logic [7:0] o_rd[2], e_rd[2];
  logic [2:0] o_lv[2], e_lv[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_fifo #(.FifoDepth(5), .DataWidth(8), .AlmostFullTh(3), .AlmostEmptyTh(1), .OutReg(1'b0)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .wvalid(wvalid), .wdata(wdata), .wready(wready0),
    .rvalid(rvalid0), .rdata(rdata0), .rready(rready), .level(level0), .almost_full(af0), .almost_empty(ae0));
  sync_fifo #(.FifoDepth(5), .DataWidth(8), .AlmostFullTh(3), .AlmostEmptyTh(1), .OutReg(1'b1)) u_oreg (
    .clk(clk), .reset(reset), .flush(flush), .wvalid(wvalid), .wdata(wdata), .wready(wready1),
    .rvalid(rvalid1), .rdata(rdata1), .rready(rready), .level(level1), .almost_full(af1), .almost_empty(ae1));

  task automatic sample;
    o_wr = '{wready0, wready1};
    o_rv = '{rvalid0, rvalid1};
    o_rd = '{rdata0, rdata1};
    o_lv = '{level0, level1};
    o_af = '{af0, af1};
    o_ae = '{ae0, ae1};
  endtask

  // One clock cycle: apply inputs, sample outputs, predict them from the queues, then advance the model.
  // An entry becomes readable 1 (OutReg=0) or 2 (OutReg=1) cycles after the cycle it was accepted.
  task automatic tick(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
    @(negedge clk);
    wvalid = wv; wdata = wd; rready = rr; flush = fl;
    #1;
    sample();
    e_lv[0] = 3'(q0.size());
    e_lv[1] = 3'(q1.size());
    e_wr[0] = live && !fl && q0.size() < 5;
    e_wr[1] = live && !fl && q1.size() < 5;
    e_rv[0] = !fl && (q0.size() > 0 ? q0[0].acc <= cyc - 1 : 1'b0);
    e_rv[1] = !fl && (q1.size() > 0 ? q1[0].acc <= cyc - 2 : 1'b0);
    e_rd[0] = q0.size() > 0 ? q0[0].d : 8'h00;
    e_rd[1] = q1.size() > 0 ? q1[0].d : 8'h00;
    for (int k = 0; k < 2; k++) begin
      e_af[k] = e_lv[k] >= 3;
      e_ae[k] = e_lv[k] <= 1;
    end
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (e_rv[0] && rr) void'(q0.pop_front());
      if (e_rv[1] && rr) void'(q1.pop_front());
      if (e_wr[0] && wv) q0.push_back('{wd, cyc});
      if (e_wr[1] && wv) q1.push_back('{wd, cyc});
    end
  endtask

  // Asserts reset mid-cycle, checks outputs before any edge, releases and checks wready timing.
  task automatic do_reset(input string tag);
    reset = 1; wvalid = 0; rready = 0; flush = 0;
    #1;
    q0.delete(); q1.delete(); live = 0;
    sample();
    for (int k = 0; k < 2; k++) begin
      total++; if (o_wr[k] !== 1'b0) $display("FAIL %s_wready[%0d]: got %b want 0", tag, k, o_wr[k]); else passed++;
      total++; if (o_rv[k] !== 1'b0) $display("FAIL %s_rvalid[%0d]: got %b want 0", tag, k, o_rv[k]); else passed++;
      total++; if (o_lv[k] !== 3'd0) $display("FAIL %s_level[%0d]: got %0d want 0", tag, k, o_lv[k]); else passed++;
      total++; if (o_af[k] !== 1'b0) $display("FAIL %s_afull[%0d]: got %b want 0", tag, k, o_af[k]); else passed++;
      total++; if (o_ae[k] !== 1'b1) $display("FAIL %s_aempty[%0d]: got %b want 1", tag, k, o_ae[k]); else passed++;
    end
    @(negedge clk);
    reset = 0;
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total++; if (o_wr[k] !== 1'b0) $display("FAIL %s_wready_early[%0d]: got %b want 0", tag, k, o_wr[k]); else passed++;
    end
    @(posedge clk);
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total++; if (o_wr[k] !== 1'b1) $display("FAIL %s_wready_release[%0d]: got %b want 1", tag, k, o_wr[k]); else passed++;
    end
    live = 1;
  endtask

  task automatic test_reset_state;
    @(negedge clk);
    #2;
    do_reset("reset_init");
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++; if (o_wr[k] !== (i <= 5)) $display("FAIL fill_wready[%0d] #%0d: got %b want %b", k, i, o_wr[k], i <= 5); else passed++;
        total++; if (o_af[k] !== (i - 1 >= 3)) $display("FAIL fill_afull[%0d] #%0d: got %b want %b", k, i, o_af[k], i - 1 >= 3); else passed++;
        total++; if (o_lv[k] !== 3'(i - 1)) $display("FAIL fill_level[%0d] #%0d: got %0d want %0d", k, i, o_lv[k], i - 1); else passed++;
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_lv[k] !== 3'd5) $display("FAIL fill_final_level[%0d]: got %0d want 5", k, o_lv[k]); else passed++;
      total++; if (o_wr[k] !== 1'b0) $display("FAIL fill_final_wready[%0d]: got %b want 0", k, o_wr[k]); else passed++;
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_d [8];
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA0, 8'hA1, 8'hA2};
    for (int i = 0; i < 8; i++) begin
      if (i == 3)
        for (int j = 0; j < 3; j++) begin
          tick(1'b1, 8'hA0 + 8'(j), 1'b0, 1'b0);
          for (int k = 0; k < 2; k++) begin
            total++; if (o_wr[k] !== 1'b1) $display("FAIL wrap_wready[%0d] #%0d: got %b want 1", k, j, o_wr[k]); else passed++;
          end
        end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++; if (o_rv[k] !== 1'b1) $display("FAIL wrap_rvalid[%0d] #%0d: got %b want 1", k, i, o_rv[k]); else passed++;
        total++; if (o_rd[k] !== exp_d[i]) $display("FAIL wrap_rdata[%0d] #%0d: got %h want %h", k, i, o_rd[k], exp_d[i]); else passed++;
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_lv[k] !== 3'd0) $display("FAIL wrap_empty_level[%0d]: got %0d want 0", k, o_lv[k]); else passed++;
      total++; if (o_ae[k] !== 1'b1) $display("FAIL wrap_empty_aempty[%0d]: got %b want 1", k, o_ae[k]); else passed++;
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] seq [10];
    seq[0] = 8'hB0;
    seq[1] = 8'hB1;
    for (int i = 2; i < 10; i++) seq[i] = 8'hC0 + 8'(i - 2);
    tick(1'b1, 8'hB0, 1'b0, 1'b0);
    tick(1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++; if (o_lv[k] !== 3'd2) $display("FAIL simul_level[%0d] #%0d: got %0d want 2", k, i, o_lv[k]); else passed++;
        total++; if (o_rv[k] !== 1'b1 || o_rd[k] !== seq[i]) $display("FAIL simul_rdata[%0d] #%0d: got %b/%h want 1/%h", k, i, o_rv[k], o_rd[k], seq[i]); else passed++;
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    tick(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_wr[k] !== 1'b0) $display("FAIL full_rw_wready[%0d]: got %b want 0", k, o_wr[k]); else passed++;
      total++; if (o_lv[k] !== 3'd5) $display("FAIL full_rw_level[%0d]: got %0d want 5", k, o_lv[k]); else passed++;
      total++; if (o_rd[k] !== 8'hC8) $display("FAIL full_rw_rdata[%0d]: got %h want c8", k, o_rd[k]); else passed++;
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_lv[k] !== 3'd4) $display("FAIL full_rw_after[%0d]: got %0d want 4", k, o_lv[k]); else passed++;
    end
  endtask

  task automatic test_flush;
    tick(1'b1, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_wr[k] !== 1'b0 || o_rv[k] !== 1'b0) $display("FAIL flush_hs[%0d]: got wready %b rvalid %b want 0 0", k, o_wr[k], o_rv[k]); else passed++;
      total++; if (o_lv[k] !== 3'd4) $display("FAIL flush_pre_level[%0d]: got %0d want 4", k, o_lv[k]); else passed++;
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_lv[k] !== 3'd0) $display("FAIL flush_level[%0d]: got %0d want 0", k, o_lv[k]); else passed++;
      total++; if (o_rv[k] !== 1'b0 || o_ae[k] !== 1'b1) $display("FAIL flush_state[%0d]: got rvalid %b aempty %b want 0 1", k, o_rv[k], o_ae[k]); else passed++;
    end
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_rv[k] !== 1'b1 || o_rd[k] !== 8'h55) $display("FAIL flush_readback[%0d]: got %b/%h want 1/55", k, o_rv[k], o_rd[k]); else passed++;
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_out_latency;
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (o_rv[0] !== 1'b1 || o_rd[0] !== 8'h11) $display("FAIL lat_fwft_c1: got %b/%h want 1/11", o_rv[0], o_rd[0]); else passed++;
    total++; if (o_rv[1] !== 1'b0) $display("FAIL lat_oreg_c1: got %b want 0", o_rv[1]); else passed++;
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (o_rv[1] !== 1'b1 || o_rd[1] !== 8'h11) $display("FAIL lat_oreg_c2: got %b/%h want 1/11", o_rv[1], o_rd[1]); else passed++;
  endtask

  task automatic test_reset_traffic;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    wvalid = 1; rready = 1;
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total++; if (o_lv[k] !== 3'd3) $display("FAIL rst_pre_level[%0d]: got %0d want 3", k, o_lv[k]); else passed++;
    end
    #1;
    do_reset("reset_mid");
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (o_lv[k] !== 3'd0 || o_rv[k] !== 1'b0) $display("FAIL rst_after[%0d]: got level %0d rvalid %b want 0 0", k, o_lv[k], o_rv[k]); else passed++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0);
      for (int k = 0; k < 2; k++) begin
        total++; if (o_wr[k] !== e_wr[k]) $display("FAIL rnd_wready[%0d] #%0d: got %b want %b", k, i, o_wr[k], e_wr[k]); else passed++;
        total++; if (o_rv[k] !== e_rv[k]) $display("FAIL rnd_rvalid[%0d] #%0d: got %b want %b", k, i, o_rv[k], e_rv[k]); else passed++;
        total++; if (o_lv[k] !== e_lv[k]) $display("FAIL rnd_level[%0d] #%0d: got %0d want %0d", k, i, o_lv[k], e_lv[k]); else passed++;
        total++; if (o_af[k] !== e_af[k] || o_ae[k] !== e_ae[k]) $display("FAIL rnd_flags[%0d] #%0d: got %b%b want %b%b", k, i, o_af[k], o_ae[k], e_af[k], e_ae[k]); else passed++;
        if (e_rv[k]) begin
          total++; if (o_rd[k] !== e_rd[k]) $display("FAIL rnd_rdata[%0d] #%0d: got %h want %h", k, i, o_rd[k], e_rd[k]); else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset_state();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_out_latency();
    test_reset_traffic();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
